// File: rtl/csa_reduce_pkg.sv
// Shared sizing helpers and per-stage control record for the carry-save reducer pipeline.
package csa_reduce_pkg;

    localparam int unsigned CTRL_TAG_W = 4;

    typedef struct packed {
        logic                  valid;
        logic [CTRL_TAG_W-1:0] tag;
    } stage_ctrl_t;

    function automatic int unsigned out_w(input int unsigned width, input int unsigned num_ops);
        return width + int'($clog2(num_ops));
    endfunction

    function automatic int unsigned levels(input int unsigned num_ops);
        return int'($clog2(num_ops)) - 1;
    endfunction

endpackage

// File: rtl/csa_4to2_row.sv
// One row of W bit-slice 4:2 compressors; purely combinational, modulo 2^W.
module csa_4to2_row #(
    parameter int unsigned W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] m0;
    logic [W-1:0] m2;
    logic [W-1:0] e_in;
    logic [W-2:0] e_out;
    logic [W-2:0] cy;

    // e_out depends only on the slice inputs, so the lateral chain never ripples
    assign m0    = c ^ d;
    assign m2    = m0 ^ a ^ b;
    assign e_out = (m0[W-2:0] & b[W-2:0]) | (~m0[W-2:0] & d[W-2:0]);
    assign e_in  = {e_out, 1'b0};
    assign cy    = (m2[W-2:0] & e_in[W-2:0]) | (~m2[W-2:0] & a[W-2:0]);
    assign sum   = e_in ^ m2;
    assign carry = {cy, 1'b0};

endmodule

// File: rtl/csa_reduce_pipe.sv
// Pipelined multi-operand carry-save reducer with valid/ready flow control.
// Define CSA_REDUCE_CPA_EN to add a final carry-propagate stage driving out_res_o.
module csa_reduce_pipe
    import csa_reduce_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_OPS = 8,
    parameter bit          SIGNED  = 1'b0,
    parameter int unsigned TAG_W   = CTRL_TAG_W,
    localparam int unsigned OUT_W  = out_w(WIDTH, NUM_OPS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops_i,
    input  logic [TAG_W-1:0]         in_tag_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [OUT_W-1:0]         out_sum_o,
    output logic [OUT_W-1:0]         out_carry_o,
    output logic [TAG_W-1:0]         out_tag_o
`ifdef CSA_REDUCE_CPA_EN
    ,
    output logic [OUT_W-1:0]         out_res_o
`endif
);

    localparam int unsigned LEVELS = levels(NUM_OPS);
`ifdef CSA_REDUCE_CPA_EN
    localparam int unsigned NST = LEVELS + 1;
`else
    localparam int unsigned NST = LEVELS;
`endif

    if (NUM_OPS < 4 || (NUM_OPS & (NUM_OPS - 1)) != 0) begin : g_bad_num_ops
        $error("csa_reduce_pipe: NUM_OPS must be a power of two and >= 4");
    end
    if (TAG_W != CTRL_TAG_W) begin : g_bad_tag_w
        $error("csa_reduce_pipe: TAG_W must equal csa_reduce_pkg::CTRL_TAG_W");
    end

    stage_ctrl_t          ctrl_q [NST];
    logic [NST:0]         load;
    logic [NST-1:0]       up_valid;
    logic [NST-1:0]       xfer;
    logic [TAG_W-1:0]     up_tag [NST];
    logic [NUM_OPS*OUT_W-1:0] ext_ops;
    logic [OUT_W-1:0]     tree_sum;
    logic [OUT_W-1:0]     tree_carry;

    // Load chain runs back from out_ready_i so empty stages accept even under stall
    always_comb begin
        up_valid[0] = in_valid_i;
        up_tag[0]   = in_tag_i;
        for (int s = 1; s < int'(NST); s++) begin
            up_valid[s] = ctrl_q[s-1].valid;
            up_tag[s]   = ctrl_q[s-1].tag;
        end
        load[NST] = out_ready_i;
        for (int s = int'(NST) - 1; s >= 0; s--) begin
            load[s] = !ctrl_q[s].valid || load[s+1];
        end
        xfer = load[NST-1:0] & up_valid;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(NST); s++) ctrl_q[s] <= '0;
        end else begin
            for (int s = 0; s < int'(NST); s++) begin
                if (load[s]) ctrl_q[s].valid <= up_valid[s];
                if (xfer[s]) ctrl_q[s].tag   <= up_tag[s];
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_OPS); k++) begin : g_ext
        if (SIGNED) begin : g_sx
            assign ext_ops[k*OUT_W +: OUT_W] =
                {{(OUT_W-WIDTH){in_ops_i[k*WIDTH+WIDTH-1]}}, in_ops_i[k*WIDTH +: WIDTH]};
        end else begin : g_zx
            assign ext_ops[k*OUT_W +: OUT_W] = {{(OUT_W-WIDTH){1'b0}}, in_ops_i[k*WIDTH +: WIDTH]};
        end
    end

    // Each level halves the vector count: groups of four become sum/carry pairs
    for (genvar l = 1; l <= int'(LEVELS); l++) begin : g_lvl
        localparam int unsigned NI = NUM_OPS >> (l - 1);
        localparam int unsigned NO = NI / 2;

        logic [NI*OUT_W-1:0] vin;
        logic [NO*OUT_W-1:0] vnext;
        logic [NO*OUT_W-1:0] vq;

        if (l == 1) begin : g_src
            assign vin = ext_ops;
        end else begin : g_src
            assign vin = g_lvl[l-1].vq;
        end

        for (genvar g = 0; g < int'(NI / 4); g++) begin : g_grp
            csa_4to2_row #(.W(OUT_W)) u_row (
                .a     (vin[(4*g+0)*OUT_W +: OUT_W]),
                .b     (vin[(4*g+1)*OUT_W +: OUT_W]),
                .c     (vin[(4*g+2)*OUT_W +: OUT_W]),
                .d     (vin[(4*g+3)*OUT_W +: OUT_W]),
                .sum   (vnext[(2*g+0)*OUT_W +: OUT_W]),
                .carry (vnext[(2*g+1)*OUT_W +: OUT_W])
            );
        end

        always_ff @(posedge clk_i) begin
            if (rst_i)            vq <= '0;
            else if (xfer[l-1])   vq <= vnext;
        end

        if (l == int'(LEVELS)) begin : g_last
            assign tree_sum   = vq[OUT_W-1:0];
            assign tree_carry = vq[2*OUT_W-1:OUT_W];
        end
    end

`ifdef CSA_REDUCE_CPA_EN
    logic [OUT_W-1:0] sum_q;
    logic [OUT_W-1:0] carry_q;
    logic [OUT_W-1:0] res_q;

    // Resolve stage keeps the carry-save pair alongside the result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q   <= '0;
            carry_q <= '0;
            res_q   <= '0;
        end else if (xfer[LEVELS]) begin
            sum_q   <= tree_sum;
            carry_q <= tree_carry;
            res_q   <= tree_sum + tree_carry;
        end
    end

    assign out_sum_o   = sum_q;
    assign out_carry_o = carry_q;
    assign out_res_o   = res_q;
`else
    assign out_sum_o   = tree_sum;
    assign out_carry_o = tree_carry;
`endif

    assign in_ready_o  = load[0];
    assign out_valid_o = ctrl_q[NST-1].valid;
    assign out_tag_o   = ctrl_q[NST-1].tag;

endmodule

// File: tb/tb_csa_reduce_pipe.sv
// Bench for csa_reduce_pipe: unsigned and signed instances share stimulus, checked against a sum model.
module tb_csa_reduce_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 8;
    localparam int unsigned OW = 11;
    localparam int unsigned TW = 4;
`ifdef CSA_REDUCE_CPA_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [N*W-1:0] ops = '0;
    logic [TW-1:0] tag = '0;

    logic          in_ready_u, out_valid_u, in_ready_s, out_valid_s;
    logic [OW-1:0] sum_u, carry_u, sum_s, carry_s, res_u, res_s;
    logic [TW-1:0] tag_u, tag_s;

    always #5 clk = ~clk;

    csa_reduce_pipe #(.WIDTH(W), .NUM_OPS(N), .SIGNED(1'b0), .TAG_W(TW)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_u),
        .in_ops_i(ops), .in_tag_i(tag), .out_valid_o(out_valid_u), .out_ready_i(out_ready),
        .out_sum_o(sum_u), .out_carry_o(carry_u), .out_tag_o(tag_u)
`ifdef CSA_REDUCE_CPA_EN
        , .out_res_o(res_u)
`endif
    );

    csa_reduce_pipe #(.WIDTH(W), .NUM_OPS(N), .SIGNED(1'b1), .TAG_W(TW)) u_dut_s (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
        .in_ops_i(ops), .in_tag_i(tag), .out_valid_o(out_valid_s), .out_ready_i(out_ready),
        .out_sum_o(sum_s), .out_carry_o(carry_s), .out_tag_o(tag_s)
`ifdef CSA_REDUCE_CPA_EN
        , .out_res_o(res_s)
`endif
    );

`ifndef CSA_REDUCE_CPA_EN
    assign res_u = '0;
    assign res_s = '0;
`endif

    typedef struct {
        logic [OW-1:0] eu;
        logic [OW-1:0] es;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t exp_cur;
    bit   exp_have;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic          obs_ready, obs_valid, obs_valid_s, obs_acc, obs_emit;
    logic [OW-1:0] obs_su, obs_ss, obs_res;
    logic [TW-1:0] obs_tag, obs_tag_s;

    // Reference: plain integer sum of the operands, wrapped to OW bits
    function automatic logic [OW-1:0] model(input logic [N*W-1:0] o, input bit sgn);
        int acc = 0;
        logic [W-1:0] b;
        for (int k = 0; k < int'(N); k++) begin
            b = o[k*W +: W];
            acc += sgn ? int'($signed(b)) : int'(b);
        end
        return OW'(acc);
    endfunction

    // Drive one cycle, sample mid-cycle, track handshakes; no checking here
    task automatic cycle(input logic v, input logic [N*W-1:0] o, input logic [TW-1:0] t, input logic r);
        in_valid  = v;
        ops       = o;
        tag       = t;
        out_ready = r;
        #4;
        obs_ready   = in_ready_u;
        obs_valid   = out_valid_u;
        obs_valid_s = out_valid_s;
        obs_su      = sum_u + carry_u;
        obs_ss      = sum_s + carry_s;
        obs_res     = res_u;
        obs_tag     = tag_u;
        obs_tag_s   = tag_s;
        obs_acc     = v && in_ready_u;
        obs_emit    = out_valid_u && r;
        if (obs_acc) sb.push_back('{model(o, 1'b0), model(o, 1'b1), t});
        exp_have = 1'b0;
        if (obs_emit && sb.size() > 0) begin
            exp_cur  = sb.pop_front();
            exp_have = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] rnd_ops();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid_u !== 1'b0 || out_valid_s !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b/%b want 0", out_valid_u, out_valid_s);
        end
        n_tests++;
        if (sum_u !== '0 || carry_u !== '0 || tag_u !== '0 || res_u !== '0) begin
            n_fail++; $display("FAIL reset_data: got sum=%h carry=%h tag=%h res=%h want 0", sum_u, carry_u, tag_u, res_u);
        end
        n_tests++;
        if (in_ready_u !== 1'b1 || in_ready_s !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b/%b want 1", in_ready_u, in_ready_s);
        end
        sb.delete();
    endtask

    task automatic test_single(input string name, input logic [N*W-1:0] o, input logic [TW-1:0] t,
                               input logic [OW-1:0] want_u, input logic [OW-1:0] want_s);
        int lat = -1;
        cycle(1'b1, o, t, 1'b1);
        n_tests++;
        if (obs_acc !== 1'b1) begin
            n_fail++; $display("FAIL %s_accept: got in_ready=%b want 1", name, obs_ready);
        end
        for (int n = 1; n <= 10; n++) begin
            cycle(1'b0, rnd_ops(), 4'($urandom()), 1'b1);
            if (obs_valid) begin
                lat = n;
                break;
            end
        end
        n_tests++;
        if (lat != LAT) begin
            n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT);
        end
        n_tests++;
        if (obs_su !== want_u || obs_ss !== want_s || obs_tag !== t || obs_tag_s !== t) begin
            n_fail++;
            $display("FAIL %s_value: got u=%h s=%h tag=%h/%h want u=%h s=%h tag=%h",
                     name, obs_su, obs_ss, obs_tag, obs_tag_s, want_u, want_s, t);
        end
        n_tests++;
        if (!exp_have || obs_su !== exp_cur.eu || obs_ss !== exp_cur.es) begin
            n_fail++; $display("FAIL %s_model: got u=%h s=%h want u=%h s=%h", name, obs_su, obs_ss, exp_cur.eu, exp_cur.es);
        end
`ifdef CSA_REDUCE_CPA_EN
        n_tests++;
        if (obs_res !== want_u || obs_res !== obs_su) begin
            n_fail++; $display("FAIL %s_res: got res=%h want %h", name, obs_res, want_u);
        end
`endif
        sb.delete();
    endtask

    task automatic test_stream();
        int sent = 0, recv = 0, gaps = 0, ready_bad = 0;
        for (int c = 0; c < 100 + LAT + 5; c++) begin
            cycle(sent < 100, rnd_ops(), 4'($urandom()), 1'b1);
            if (sent < 100 && !obs_ready) ready_bad++;
            if (obs_acc) sent++;
            if (recv > 0 && recv < 100 && !obs_valid) gaps++;
            if (obs_emit) begin
                recv++;
                n_tests++;
                if (!exp_have || obs_su !== exp_cur.eu || obs_ss !== exp_cur.es ||
                    obs_tag !== exp_cur.tag || obs_tag_s !== exp_cur.tag || obs_valid_s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_data[%0d]: got u=%h s=%h tag=%h want u=%h s=%h tag=%h",
                             recv, obs_su, obs_ss, obs_tag, exp_cur.eu, exp_cur.es, exp_cur.tag);
                end
`ifdef CSA_REDUCE_CPA_EN
                if (exp_have && obs_res !== exp_cur.eu) begin
                    n_fail++; $display("FAIL stream_res[%0d]: got %h want %h", recv, obs_res, exp_cur.eu);
                end
`endif
            end
        end
        n_tests++;
        if (recv != 100) begin
            n_fail++; $display("FAIL stream_count: got %0d want 100", recv);
        end
        n_tests++;
        if (gaps != 0 || ready_bad != 0) begin
            n_fail++; $display("FAIL stream_rate: got gaps=%0d ready_low=%0d want 0/0", gaps, ready_bad);
        end
        sb.delete();
    endtask

    task automatic test_stall();
        int acc = 0, unstable = 0, recv = 0;
        bit held = 1'b0;
        logic [OW-1:0] h_su, h_ss;
        logic [TW-1:0] h_tag;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, rnd_ops(), 4'($urandom()), 1'b0);
            if (obs_acc) acc++;
            if (held && (obs_su !== h_su || obs_ss !== h_ss || obs_tag !== h_tag || !obs_valid)) unstable++;
            if (!held && obs_valid) begin
                held = 1'b1; h_su = obs_su; h_ss = obs_ss; h_tag = obs_tag;
            end
        end
        n_tests++;
        if (acc != LAT || obs_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_fill: got accepted=%0d in_ready=%b want %0d/0", acc, obs_ready, LAT);
        end
        n_tests++;
        if (!held || unstable != 0) begin
            n_fail++; $display("FAIL stall_hold: got held=%0b unstable=%0d want 1/0", held, unstable);
        end
        cycle(1'b0, rnd_ops(), '0, 1'b1);
        n_tests++;
        if (obs_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_ready: got %b want 1", obs_ready);
        end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) cycle(1'b0, rnd_ops(), '0, 1'b1);
            if (obs_emit) begin
                recv++;
                n_tests++;
                if (!exp_have || obs_su !== exp_cur.eu || obs_ss !== exp_cur.es || obs_tag !== exp_cur.tag) begin
                    n_fail++;
                    $display("FAIL stall_drain[%0d]: got u=%h s=%h tag=%h want u=%h s=%h tag=%h",
                             recv, obs_su, obs_ss, obs_tag, exp_cur.eu, exp_cur.es, exp_cur.tag);
                end
            end
        end
        n_tests++;
        if (recv != LAT) begin
            n_fail++; $display("FAIL stall_drain_count: got %0d want %0d", recv, LAT);
        end
        sb.delete();
    endtask

    task automatic test_reset_flight();
        int stale = 0;
        cycle(1'b1, rnd_ops(), 4'hA, 1'b0);
        cycle(1'b1, rnd_ops(), 4'hB, 1'b0);
        rst = 1'b1;
        cycle(1'b0, '0, '0, 1'b0);
        rst = 1'b0;
        sb.delete();
        n_tests++;
        if (out_valid_u !== 1'b0 || sum_u !== '0 || carry_u !== '0 || tag_u !== '0 || in_ready_u !== 1'b1) begin
            n_fail++;
            $display("FAIL flight_reset: got valid=%b sum=%h carry=%h tag=%h ready=%b want 0/0/0/0/1",
                     out_valid_u, sum_u, carry_u, tag_u, in_ready_u);
        end
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, rnd_ops(), '0, 1'b1);
            if (obs_valid || obs_valid_s) stale++;
        end
        n_tests++;
        if (stale != 0) begin
            n_fail++; $display("FAIL flight_stale: got %0d stale outputs want 0", stale);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single("all_ff", {8{8'hFF}}, 4'h5, 11'h7F8, 11'h7F8);
        test_single("mixed_sign", {{4{8'h7F}}, {4{8'h80}}}, 4'h9, 11'h3FC, 11'h7FC);
        test_single("ones_to_eight", 64'h0807060504030201, 4'h3, 11'd36, 11'd36);
        test_stream();
        test_stall();
        test_reset_flight();
        test_single("after_reset", {8{8'h01}}, 4'hC, 11'd8, 11'd8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
